uart_tx_fifo: RTL and testbench

//  Buffered UART transmitter. Accepts bytes via valid/ready handshake into an internal FIFO
//  and serialises them 8N1/8E1/8O1 (1 or 2 stop bits) on tx_o.

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO in front of an 8-bit serialiser with
// optional parity and one or two stop bits. Bit time is 16*(baud_div_i+1) clocks.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   baud_div_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          tx_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          ready_q;
  logic          push, pop;

  state_e        state_q, state_d;
  logic [15:0]   pre_q, div_q;
  logic [3:0]    sub_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, data_q;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          tick, bit_end;

  // ready is registered, so a push can never land in a full FIFO even if a pop
  // happens in the same cycle.
  assign push    = valid_i & ready_q;
  assign count_d = count_q + LW'(push) - LW'(pop);

  assign tick    = (pre_q == div_q);
  assign bit_end = tick && (sub_q == 4'hF);

  // FIFO storage; no reset needed since contents are qualified by count_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != LW'(FIFO_DEPTH));
    end
  end

  // Next-state, pop request, done pulse and line level for the next cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) state_d = StData;
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end && (bit_q == 3'd7)) state_d = (PARITY_EN != 0) ? StParity : StStop;
      end
      StParity: begin
        tx_d = (^data_q) ^ 1'(PARITY_ODD);
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end && (bit_q == 3'(STOP_BITS - 1))) begin
          done_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Serialiser state: prescaler, sub-bit and bit counters, shift register, line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pre_q   <= '0;
      div_q   <= '0;
      sub_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      if (state_q == StIdle) begin
        pre_q <= '0;
        sub_q <= '0;
      end else begin
        pre_q <= tick ? 16'd0 : pre_q + 16'd1;
        if (tick) sub_q <= sub_q + 4'd1;
      end
      // bit_q counts data bits in StData and stop bits in StStop.
      if (state_d != state_q) bit_q <= '0;
      else if (bit_end)       bit_q <= bit_q + 3'd1;
      if (pop) begin
        shift_q <= mem_q[rptr_q];
        data_q  <= mem_q[rptr_q];
        div_q   <= baud_div_i;
      end else if (state_q == StData && bit_end) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  assign ready_o = ready_q;
  assign level_o = count_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;
  assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: timing, FIFO fill, parity/stop options,
// mid-frame reset and baud change, with a serial line monitor on the main DUT.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [7:0]  data, data_p;
  logic        valid, valid_p;
  logic        ready, busy, done, tx;
  logic [4:0]  level;
  logic        ready_p, busy_p, done_p, tx_p;
  logic [2:0]  level_p;
  logic        ready_q2, busy_q2, done_q2, tx_q2;
  logic [2:0]  level_q2;

  int nvec = 0;
  int nerr = 0;
  int cyc_cnt = 0;
  int bit_clk = 432;
  logic [7:0] rx_q[$];
  int         st_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  uart_tx_fifo dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .data_i(data), .valid_i(valid),
    .ready_o(ready), .level_o(level), .busy_o(busy), .done_o(done), .tx_o(tx)
  );

  uart_tx_fifo #(.FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .data_i(data_p), .valid_i(valid_p),
    .ready_o(ready_p), .level_o(level_p), .busy_o(busy_p), .done_o(done_p), .tx_o(tx_p)
  );

  uart_tx_fifo #(.FIFO_DEPTH(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .data_i(data_p), .valid_i(valid_p),
    .ready_o(ready_q2), .level_o(level_q2), .busy_o(busy_q2), .done_o(done_q2), .tx_o(tx_q2)
  );

  // Line monitor: samples mid-bit using the bit length current at the start edge.
  initial begin
    forever begin
      int bc;
      logic [7:0] b;
      @(negedge tx);
      bc = bit_clk;
      st_q.push_back(cyc_cnt);
      repeat (bc / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (bc) @(negedge clk);
        b[i] = tx;
      end
      repeat (bc) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  exp1;
    logic [23:0] exp_e, exp_o;
    logic [7:0]  bytes [20];
    logic        saw_low, level_chk_done;
    int          bound;

    rst_n = 1'b0; baud_div = 16'd26; data = '0; valid = 1'b0; data_p = '0; valid_p = 1'b0;
    cyc(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // Single byte 0x55 at baud_div=26 (432 clk/bit).
    exp1 = 10'h2AA;
    data = 8'h55; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    chk("t1_level_push", 32'(level), 32'd1);
    chk("t1_tx_e0", 32'(tx), 32'd1);
    cyc(1);
    chk("t1_level_pop", 32'(level), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_tx_e1", 32'(tx), 32'd1);
    cyc(1);
    chk("t1_tx_e2", 32'(tx), 32'd0);
    cyc(216);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t1_bit%0d", i), 32'(tx), 32'(exp1[i]));
      if (i < 9) cyc(432);
    end
    cyc(214);
    chk("t1_done_early", 32'(done), 32'd0);
    chk("t1_busy_early", 32'(busy), 32'd1);
    cyc(1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    cyc(1);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_rx", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h55);

    // Fill: 20 bytes held on valid at baud_div=0.
    baud_div = 16'd0; bit_clk = 16;
    rx_q.delete(); st_q.delete();
    for (int i = 0; i < 20; i++) bytes[i] = 8'(8'h11 * i + 8'h3);
    saw_low = 1'b0; level_chk_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data = bytes[i]; valid = 1'b1;
      bound = 0;
      while (!ready && bound < 2000) begin
        saw_low = 1'b1;
        if (!level_chk_done) begin
          chk("t2_full_level", 32'(level), 32'd16);
          level_chk_done = 1'b1;
        end
        cyc(1); bound++;
      end
      chk($sformatf("t2_wait%0d", i), 32'(bound < 2000), 32'd1);
      cyc(1);
    end
    valid = 1'b0;
    chk("t2_ready_dropped", 32'(saw_low), 32'd1);
    bound = 0;
    while ((busy || level != 0) && bound < 5000) begin cyc(1); bound++; end
    chk("t2_drain", 32'(bound < 5000), 32'd1);
    cyc(20);
    chk("t2_count", 32'(rx_q.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("t2_byte%0d", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hdead,
          32'(bytes[i]));
    chk("t2_spacing", (st_q.size() > 1) ? 32'(st_q[1] - st_q[0]) : 32'hdead, 32'd160);

    // Parity (even/odd) with two stop bits, two bytes back to back.
    exp_e = 24'hF00E0E;
    exp_o = 24'hD00C0E;
    data_p = 8'h07; valid_p = 1'b1;
    cyc(1);
    data_p = 8'h80;
    cyc(1);
    valid_p = 1'b0;
    cyc(1);
    cyc(8);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t3_even_bit%0d", i), 32'(tx_p), 32'(exp_e[i]));
      chk($sformatf("t3_odd_bit%0d", i), 32'(tx_q2), 32'(exp_o[i]));
      if (i < 23) cyc(16);
    end
    cyc(20);
    chk("t3_busy_end", 32'(busy_p), 32'd0);
    chk("t3_level_end", 32'(level_p), 32'd0);

    // Reset mid-DATA with 5 bytes queued.
    for (int i = 0; i < 6; i++) begin
      data = 8'(8'hC0 + i); valid = 1'b1;
      cyc(1);
    end
    valid = 1'b0;
    chk("t5_level_q", 32'(level), 32'd5);
    cyc(40);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_tx", 32'(tx), 32'd1);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    cyc(3);
    chk("t5_done_hold", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc(200);
    chk("t5_idle_after", 32'(busy), 32'd0);
    chk("t5_level_after", 32'(level), 32'd0);
    rx_q.delete(); st_q.delete();
    data = 8'hA3; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    cyc(2);
    bound = 0;
    while (busy && bound < 400) begin cyc(1); bound++; end
    chk("t5_frame_end", 32'(bound < 400), 32'd1);
    cyc(10);
    chk("t5_rx_count", 32'(rx_q.size()), 32'd1);
    chk("t5_rx_a3", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hdead, 32'hA3);

    // Baud change mid-frame applies to the next frame only.
    rx_q.delete(); st_q.delete();
    data = 8'h3C; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    cyc(40);
    baud_div = 16'd1;
    data = 8'hC3; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    bound = 0;
    while (rx_q.size() < 1 && bound < 400) begin cyc(1); bound++; end
    bit_clk = 32;
    chk("t6_rx1_wait", 32'(bound < 400), 32'd1);
    bound = 0;
    while (rx_q.size() < 2 && bound < 800) begin cyc(1); bound++; end
    chk("t6_rx2_wait", 32'(bound < 800), 32'd1);
    chk("t6_byte0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hdead, 32'h3C);
    chk("t6_byte1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hdead, 32'hC3);
    chk("t6_spacing", (st_q.size() > 1) ? 32'(st_q[1] - st_q[0]) : 32'hdead, 32'd160);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
